bcd_countdown_timer: RTL and testbench

//  Parametrised N-digit BCD countdown for the bomb game. Counts down once per
//  sec_tick and supports pause/resume, multi-second strike penalties and a

---
 rtl/bcd_countdown_timer_if.sv | 26 ++
 rtl/bcd_countdown_timer.sv | 153 +++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bcd_countdown_timer_if.sv
// rtl/bcd_countdown_timer_if.sv - control/status bundle for the BCD countdown timer
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] init_time;
  logic                load;
  logic                start_stop;
  logic                sec_tick;
  logic                strike;
  logic [4*DIGITS-1:0] count_bcd;
  logic                running;
  logic                penalty_busy;
  logic                warn;
  logic [3:0]          strikes;
  logic                expired;

  modport master (
    output init_time, load, start_stop, sec_tick, strike,
    input  count_bcd, running, penalty_busy, warn, strikes, expired
  );

  modport slave (
    input  init_time, load, start_stop, sec_tick, strike,
    output count_bcd, running, penalty_busy, warn, strikes, expired
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - N-digit BCD countdown with pause, strike penalties and expiry
module bcd_countdown_timer #(
  parameter int              DIGITS       = 4,
  parameter int              PENALTY_SECS = 10,
  parameter int              MAX_STRIKES  = 3,
  parameter logic [4*DIGITS-1:0] WARN_BCD = 'h0010
) (
  input logic clk,
  input logic reset,
  bcd_countdown_timer_if.slave bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_PENALTY,
    S_EXPIRED
  } state_t;

  state_t      state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [3:0]  strikes_q, strikes_d;
  logic [7:0]  pen_q, pen_d;
  logic [9:0]  pen_sum;
  logic        running_q, running_d;
  logic        busy_q, busy_d;
  logic        warn_q, warn_d;
  logic        expired_q, expired_d;

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Only ever called with a nonzero count, so the borrow never falls off the MSD.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    strikes_d = strikes_q;
    pen_d     = pen_q;
    pen_sum   = 10'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.load) count_d = bcd_clamp(bus.init_time);
        if (bus.start_stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.start_stop) begin
          state_d = S_PAUSE;
        end else if (bus.strike) begin
          strikes_d = strikes_q + 4'd1;
          if (strikes_d == 4'(MAX_STRIKES)) begin
            state_d = S_EXPIRED;
          end else begin
            pen_d   = 8'(PENALTY_SECS);
            state_d = S_PENALTY;
          end
        end else if (bus.sec_tick) begin
          if (count_q == '0) state_d = S_EXPIRED;
          else               count_d = bcd_dec(count_q);
        end
      end
      S_PAUSE: begin
        if (bus.load) count_d = bcd_clamp(bus.init_time);
        if (bus.start_stop) state_d = S_RUN;
      end
      S_PENALTY: begin
        if (count_q == '0) begin
          state_d = S_EXPIRED;
          pen_d   = 8'd0;
        end else begin
          if (bus.strike) strikes_d = strikes_q + 4'd1;
          if (bus.strike && strikes_d == 4'(MAX_STRIKES)) begin
            state_d = S_EXPIRED;
            pen_d   = 8'd0;
          end else begin
            count_d = bcd_dec(count_q);
            // pen_q >= 1 while in penalty, so the -1 cannot underflow.
            pen_sum = {2'b00, pen_q} + 10'(bus.sec_tick)
                    + (bus.strike ? 10'(PENALTY_SECS) : 10'd0) - 10'd1;
            pen_d   = (pen_sum > 10'd255) ? 8'd255 : pen_sum[7:0];
            if (pen_sum == 10'd0) state_d = S_RUN;
          end
        end
      end
      S_EXPIRED: begin
        state_d = S_EXPIRED;
      end
      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN) || (state_d == S_PENALTY);
    busy_d    = (state_d == S_PENALTY);
    expired_d = (state_d == S_EXPIRED);
    // Valid BCD orders the same as binary, so a plain compare suffices.
    warn_d    = ((state_d == S_RUN) || (state_d == S_PAUSE) || (state_d == S_PENALTY))
                && (count_d <= WARN_BCD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= bcd_clamp(bus.init_time);
      strikes_q <= 4'd0;
      pen_q     <= 8'd0;
      running_q <= 1'b0;
      busy_q    <= 1'b0;
      warn_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      strikes_q <= strikes_d;
      pen_q     <= pen_d;
      running_q <= running_d;
      busy_q    <= busy_d;
      warn_q    <= warn_d;
      expired_q <= expired_d;
    end
  end

  assign bus.count_bcd    = count_q;
  assign bus.running      = running_q;
  assign bus.penalty_busy = busy_q;
  assign bus.warn         = warn_q;
  assign bus.strikes      = strikes_q;
  assign bus.expired      = expired_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed vector bench for bcd_countdown_timer
module tb_bcd_countdown_timer;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.DIGITS(4)) bus ();

  bcd_countdown_timer #(
    .DIGITS(4), .PENALTY_SECS(10), .MAX_STRIKES(3), .WARN_BCD(16'h0010)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        ld, ss, tk, st;
    logic [15:0] cnt;
    logic        run, pen, warn;
    logic [3:0]  stk;
    logic        exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ld, ss, tk, st, input logic [15:0] cnt,
                              input logic run, pen, warn, input logic [3:0] stk,
                              input logic exp);
    vec_t v;
    v.ld = ld; v.ss = ss; v.tk = tk; v.st = st; v.cnt = cnt;
    v.run = run; v.pen = pen; v.warn = warn; v.stk = stk; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, want);
    end
  endtask

  task automatic check_all(input string name, input logic [15:0] cnt, input logic run,
                           input logic pen, input logic warn, input logic [3:0] stk,
                           input logic exp);
    check({name, ".count"},   bus.count_bcd,           cnt);
    check({name, ".running"}, 16'(bus.running),        16'(run));
    check({name, ".busy"},    16'(bus.penalty_busy),   16'(pen));
    check({name, ".warn"},    16'(bus.warn),           16'(warn));
    check({name, ".strikes"}, 16'(bus.strikes),        16'(stk));
    check({name, ".expired"}, 16'(bus.expired),        16'(exp));
  endtask

  task automatic step(input logic ld, ss, tk, st);
    bus.load = ld; bus.start_stop = ss; bus.sec_tick = tk; bus.strike = st;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.start_stop = 1'b0; bus.sec_tick = 1'b0; bus.strike = 1'b0;
  endtask

  task automatic do_reset(input logic [15:0] init);
    bus.init_time = init;
    bus.load = 1'b0; bus.start_stop = 1'b0; bus.sec_tick = 1'b0; bus.strike = 1'b0;
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    // Main scenario, init 0x0102: borrow chain, pause, reload, penalty with tick.
    add(0,1,0,0, 16'h0102, 1,0,0, 0, 0);
    add(0,0,1,0, 16'h0101, 1,0,0, 0, 0);
    add(0,0,1,0, 16'h0100, 1,0,0, 0, 0);
    add(0,0,1,0, 16'h0099, 1,0,0, 0, 0);
    add(0,0,1,0, 16'h0098, 1,0,0, 0, 0);
    add(0,0,0,0, 16'h0098, 1,0,0, 0, 0);
    add(0,1,1,0, 16'h0098, 0,0,0, 0, 0);
    add(0,0,1,0, 16'h0098, 0,0,0, 0, 0);
    add(0,0,0,1, 16'h0098, 0,0,0, 0, 0);
    add(1,0,0,0, 16'h0102, 0,0,0, 0, 0);
    add(0,1,0,0, 16'h0102, 1,0,0, 0, 0);
    add(0,0,0,1, 16'h0102, 1,1,0, 1, 0);
    add(0,0,0,0, 16'h0101, 1,1,0, 1, 0);
    add(0,0,1,0, 16'h0100, 1,1,0, 1, 0);
    add(0,0,0,0, 16'h0099, 1,1,0, 1, 0);
    add(0,0,0,0, 16'h0098, 1,1,0, 1, 0);
    add(0,0,0,0, 16'h0097, 1,1,0, 1, 0);
    add(0,0,0,0, 16'h0096, 1,1,0, 1, 0);
    add(0,0,0,0, 16'h0095, 1,1,0, 1, 0);
    add(0,0,0,0, 16'h0094, 1,1,0, 1, 0);
    add(0,1,0,0, 16'h0093, 1,1,0, 1, 0);
    add(0,0,0,0, 16'h0092, 1,1,0, 1, 0);
    add(0,0,0,0, 16'h0091, 1,0,0, 1, 0);
    add(0,0,1,0, 16'h0090, 1,0,0, 1, 0);

    do_reset(16'h0102);
    check_all("reset", 16'h0102, 0,0,0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ld, vecs[i].ss, vecs[i].tk, vecs[i].st);
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].run, vecs[i].pen,
                vecs[i].warn, vecs[i].stk, vecs[i].exp);
    end

    // Expiry on tick at zero, then everything ignored.
    do_reset(16'h0001);
    step(0,1,0,0);
    step(0,0,1,0);
    check_all("zero", 16'h0000, 1,0,1, 0, 0);
    step(0,0,1,0);
    check_all("expire", 16'h0000, 0,0,0, 0, 1);
    step(0,1,1,0);
    step(1,0,0,1);
    step(0,1,0,0);
    check_all("exp_hold", 16'h0000, 0,0,0, 0, 1);

    // Penalty length and warn threshold.
    do_reset(16'h0030);
    step(0,1,0,0);
    step(0,0,0,1);
    n = bus.penalty_busy ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      step(0,0,0,0);
      if (bus.penalty_busy) n++;
      else break;
    end
    check("pen_len", 16'(n), 16'd10);
    check_all("pen_done", 16'h0020, 1,0,0, 1, 0);
    for (int i = 0; i < 9; i++) step(0,0,1,0);
    check_all("warn_pre", 16'h0011, 1,0,0, 1, 0);
    step(0,0,1,0);
    check_all("warn_on", 16'h0010, 1,0,1, 1, 0);

    // Count runs out during penalty.
    do_reset(16'h0005);
    step(0,1,0,0);
    step(0,0,0,1);
    for (int i = 0; i < 5; i++) step(0,0,0,0);
    check_all("pen_zero", 16'h0000, 1,1,1, 1, 0);
    step(0,0,0,0);
    check_all("pen_expire", 16'h0000, 0,0,0, 1, 1);

    // Strike limit.
    do_reset(16'h0100);
    step(0,1,0,0);
    step(0,0,0,1);
    for (int i = 0; i < 10; i++) step(0,0,0,0);
    check_all("strike1", 16'h0090, 1,0,0, 1, 0);
    step(0,0,0,1);
    for (int i = 0; i < 10; i++) step(0,0,0,0);
    check_all("strike2", 16'h0080, 1,0,0, 2, 0);
    step(0,0,0,1);
    check_all("strike3", 16'h0080, 0,0,0, 3, 1);

    // Reset in the middle of a penalty discards it.
    do_reset(16'h0050);
    step(0,1,0,0);
    step(0,0,0,1);
    for (int i = 0; i < 3; i++) step(0,0,0,0);
    do_reset(16'h0050);
    check_all("rst_mid", 16'h0050, 0,0,0, 0, 0);
    step(0,1,0,0);
    step(0,0,1,0);
    check_all("rst_resume", 16'h0049, 1,0,0, 0, 0);

    // Non-BCD init nibbles clamp to 9.
    do_reset(16'hA9F3);
    check_all("clamp", 16'h9993, 0,0,0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
